// File: rtl/gecko_reg_scoreboard_if.sv
// Purpose: bundles the decode-side issue, bypass, retire, flush and status signals of the register scoreboard.
// Latency: n/a (wires only); issue_ready is combinational, all status outputs are registered in the scoreboard.
// Backpressure: decode holds issue_* while issue_ready is low; retire and flush are unconditional strobes.
// Ports: master = decode/writeback side (drives requests), slave = scoreboard (drives ready and status).
interface gecko_reg_scoreboard_if #(
    parameter int NUM_REGS      = 32,
    parameter int COUNTER_WIDTH = 2,
    parameter int RETIRE_PORTS  = 2
);
    localparam int ADDR_W  = $clog2(NUM_REGS);
    localparam int MAX     = (1 << COUNTER_WIDTH) - 1;
    localparam int TOTAL_W = $clog2(NUM_REGS * MAX + 1);

    logic                           issue_valid;
    logic                           issue_ready;
    logic [ADDR_W-1:0]              issue_rs1;
    logic [ADDR_W-1:0]              issue_rs2;
    logic [ADDR_W-1:0]              issue_rd;
    logic                           issue_rs1_used;
    logic                           issue_rs2_used;
    logic                           issue_rd_used;
    logic                           bypass_valid;
    logic [ADDR_W-1:0]              bypass_reg;
    logic [RETIRE_PORTS-1:0]        retire_valid;
    logic [RETIRE_PORTS*ADDR_W-1:0] retire_rd;
    logic                           flush;
    logic [NUM_REGS-1:0]            reg_busy;
    logic [TOTAL_W-1:0]             outstanding_total;
    logic                           underflow_error;

    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_rd,
        output issue_rs1_used, issue_rs2_used, issue_rd_used,
        output bypass_valid, bypass_reg, retire_valid, retire_rd, flush,
        input  issue_ready, reg_busy, outstanding_total, underflow_error
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_rd,
        input  issue_rs1_used, issue_rs2_used, issue_rd_used,
        input  bypass_valid, bypass_reg, retire_valid, retire_rd, flush,
        output issue_ready, reg_busy, outstanding_total, underflow_error
    );
endinterface

// File: rtl/gecko_reg_scoreboard.sv
// Purpose: per-register outstanding-writeback counters gating decode issue on operand/destination hazards.
// Latency: issue_ready combinational from registered counters; counter/busy/total updates visible next cycle.
// Backpressure: issue_ready low stalls decode; retires and flush are always absorbed (never stalled).
// Ports: clk, rst_n (async active-low) plus the slave side of gecko_reg_scoreboard_if.
module gecko_reg_scoreboard #(
    parameter int NUM_REGS      = 32,
    parameter int COUNTER_WIDTH = 2,
    parameter int RETIRE_PORTS  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gecko_reg_scoreboard_if.slave sb
);
    localparam int ADDR_W  = $clog2(NUM_REGS);
    localparam int MAX     = (1 << COUNTER_WIDTH) - 1;
    localparam int TOTAL_W = $clog2(NUM_REGS * MAX + 1);

    logic [COUNTER_WIDTH-1:0] counter_q [NUM_REGS];
    logic [COUNTER_WIDTH-1:0] counter_d [NUM_REGS];
    logic [TOTAL_W-1:0]       total_q;
    logic [TOTAL_W-1:0]       total_d;
    logic                     underflow_q;
    logic                     underflow_d;

    logic [COUNTER_WIDTH-1:0] rs1_cnt;
    logic [COUNTER_WIDTH-1:0] rs2_cnt;
    logic [COUNTER_WIDTH-1:0] rd_cnt;
    logic                     rs1_ok;
    logic                     rs2_ok;
    logic                     rd_ok;
    logic                     issue_ready;
    logic                     accept;
    logic [NUM_REGS-1:0]      reg_busy;

    // Hazard check: only registered counters and current issue/bypass/flush
    // inputs feed issue_ready, so there is no retire-to-ready path.
    always_comb begin
        rs1_cnt = counter_q[sb.issue_rs1];
        rs2_cnt = counter_q[sb.issue_rs2];
        rd_cnt  = counter_q[sb.issue_rd];

        // Bypass only helps when exactly one write is in flight; with two the
        // forwarded value may be superseded by the younger writer.
        rs1_ok = (sb.issue_rs1 == '0) || (rs1_cnt == '0) ||
                 (sb.bypass_valid && (sb.bypass_reg == sb.issue_rs1) &&
                  (rs1_cnt == COUNTER_WIDTH'(1)));
        rs2_ok = (sb.issue_rs2 == '0) || (rs2_cnt == '0) ||
                 (sb.bypass_valid && (sb.bypass_reg == sb.issue_rs2) &&
                  (rs2_cnt == COUNTER_WIDTH'(1)));
        rd_ok  = (sb.issue_rd == '0) || (rd_cnt != COUNTER_WIDTH'(MAX));

        issue_ready = !sb.flush &&
                      (!sb.issue_rs1_used || rs1_ok) &&
                      (!sb.issue_rs2_used || rs2_ok) &&
                      (!sb.issue_rd_used  || rd_ok);
        accept = sb.issue_valid && issue_ready;
    end

    // Counter update: per register, inc (at most 1) minus the retire count,
    // with the decrement clamped at zero and any clamped amount flagged.
    always_comb begin
        int inc;
        int dec_req;
        int avail;
        int dec_app;
        int total_inc;
        int total_dec;

        total_inc   = 0;
        total_dec   = 0;
        underflow_d = underflow_q;
        for (int r = 0; r < NUM_REGS; r++) begin
            counter_d[r] = '0;
        end

        for (int r = 1; r < NUM_REGS; r++) begin
            inc = (accept && sb.issue_rd_used && (sb.issue_rd == ADDR_W'(r))) ? 1 : 0;
            dec_req = 0;
            for (int p = 0; p < RETIRE_PORTS; p++) begin
                if (sb.retire_valid[p] && (sb.retire_rd[p*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
                    dec_req = dec_req + 1;
                end
            end
            avail   = int'(counter_q[r]) + inc;
            dec_app = (dec_req > avail) ? avail : dec_req;
            if ((dec_req > avail) && !sb.flush) begin
                underflow_d = 1'b1;
            end
            counter_d[r] = COUNTER_WIDTH'(avail - dec_app);
            total_inc    = total_inc + inc;
            total_dec    = total_dec + dec_app;
        end

        total_d = TOTAL_W'(int'(total_q) + total_inc - total_dec);

        if (sb.flush) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                counter_d[r] = '0;
            end
            total_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                counter_q[r] <= '0;
            end
            total_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                counter_q[r] <= counter_d[r];
            end
            total_q     <= total_d;
            underflow_q <= underflow_d;
        end
    end

    always_comb begin
        reg_busy = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            reg_busy[r] = (counter_q[r] != '0);
        end
    end

    assign sb.issue_ready       = issue_ready;
    assign sb.reg_busy          = reg_busy;
    assign sb.outstanding_total = total_q;
    assign sb.underflow_error   = underflow_q;
endmodule

// File: tb/tb_gecko_reg_scoreboard.sv
module tb_gecko_reg_scoreboard;
    localparam int NUM_REGS      = 32;
    localparam int COUNTER_WIDTH = 2;
    localparam int RETIRE_PORTS  = 2;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    gecko_reg_scoreboard_if #(
        .NUM_REGS(NUM_REGS), .COUNTER_WIDTH(COUNTER_WIDTH), .RETIRE_PORTS(RETIRE_PORTS)
    ) sb_if ();

    gecko_reg_scoreboard #(
        .NUM_REGS(NUM_REGS), .COUNTER_WIDTH(COUNTER_WIDTH), .RETIRE_PORTS(RETIRE_PORTS)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .sb   (sb_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        sb_if.issue_valid    = 1'b0;
        sb_if.issue_rs1      = '0;
        sb_if.issue_rs2      = '0;
        sb_if.issue_rd       = '0;
        sb_if.issue_rs1_used = 1'b0;
        sb_if.issue_rs2_used = 1'b0;
        sb_if.issue_rd_used  = 1'b0;
        sb_if.bypass_valid   = 1'b0;
        sb_if.bypass_reg     = '0;
        sb_if.retire_valid   = '0;
        sb_if.retire_rd      = '0;
        sb_if.flush          = 1'b0;
    endtask

    // Advance one clock edge, settle, then return inputs to idle.
    task automatic step();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    task automatic issue_rd(input logic [4:0] rd);
        sb_if.issue_valid   = 1'b1;
        sb_if.issue_rd      = rd;
        sb_if.issue_rd_used = 1'b1;
        step();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;

        // Reset state
        check("rst_busy", 64'(sb_if.reg_busy), 64'h0);
        check("rst_total", 64'(sb_if.outstanding_total), 64'd0);
        check("rst_uf", 64'(sb_if.underflow_error), 64'd0);
        check("rst_ready", 64'(sb_if.issue_ready), 64'd1);

        // Basic RAW hazard on r5
        issue_rd(5'd5);
        check("r5_busy", 64'(sb_if.reg_busy), 64'h20);
        check("r5_total", 64'(sb_if.outstanding_total), 64'd1);
        sb_if.issue_rs1 = 5'd5; sb_if.issue_rs1_used = 1'b1;
        sb_if.retire_valid = 2'b01; sb_if.retire_rd = {5'd0, 5'd5};
        #1;
        check("r5_blocked_same_cycle_retire", 64'(sb_if.issue_ready), 64'd0);
        step();
        sb_if.issue_rs1 = 5'd5; sb_if.issue_rs1_used = 1'b1;
        #1;
        check("r5_ready_after_retire", 64'(sb_if.issue_ready), 64'd1);
        check("r5_total_zero", 64'(sb_if.outstanding_total), 64'd0);
        idle();

        // Saturation at MAX=3 on r3
        issue_rd(5'd3); issue_rd(5'd3); issue_rd(5'd3);
        check("r3_total3", 64'(sb_if.outstanding_total), 64'd3);
        check("r3_busy", 64'(sb_if.reg_busy), 64'h08);
        sb_if.issue_rd = 5'd3; sb_if.issue_rd_used = 1'b1;
        #1;
        check("r3_full_blocked", 64'(sb_if.issue_ready), 64'd0);
        sb_if.issue_rd = 5'd4;
        #1;
        check("r4_writeable", 64'(sb_if.issue_ready), 64'd1);
        sb_if.issue_rd = 5'd3;
        sb_if.retire_valid = 2'b01; sb_if.retire_rd = {5'd0, 5'd3};
        #1;
        check("r3_full_retire_same_cycle", 64'(sb_if.issue_ready), 64'd0);
        step();
        sb_if.issue_rd = 5'd3; sb_if.issue_rd_used = 1'b1;
        #1;
        check("r3_ready_after_retire", 64'(sb_if.issue_ready), 64'd1);
        check("r3_total2", 64'(sb_if.outstanding_total), 64'd2);
        idle();
        sb_if.retire_valid = 2'b11; sb_if.retire_rd = {5'd3, 5'd3};
        step();
        check("r3_drained_total", 64'(sb_if.outstanding_total), 64'd0);
        check("r3_drained_uf", 64'(sb_if.underflow_error), 64'd0);

        // Register 0 is never tracked
        sb_if.issue_valid = 1'b1; sb_if.issue_rd = 5'd0; sb_if.issue_rd_used = 1'b1;
        sb_if.retire_valid = 2'b01; sb_if.retire_rd = {5'd0, 5'd0};
        step();
        check("r0_busy", 64'(sb_if.reg_busy), 64'h0);
        check("r0_total", 64'(sb_if.outstanding_total), 64'd0);
        check("r0_uf", 64'(sb_if.underflow_error), 64'd0);
        issue_rd(5'd1);
        sb_if.issue_rs1 = 5'd0; sb_if.issue_rs1_used = 1'b1;
        #1;
        check("r0_readable", 64'(sb_if.issue_ready), 64'd1);
        idle();

        // Flush with total=5, simultaneous issue and a clamped retire
        issue_rd(5'd2); issue_rd(5'd3); issue_rd(5'd4); issue_rd(5'd5);
        check("pre_flush_total", 64'(sb_if.outstanding_total), 64'd5);
        sb_if.flush = 1'b1;
        sb_if.issue_valid = 1'b1; sb_if.issue_rd = 5'd6; sb_if.issue_rd_used = 1'b1;
        sb_if.retire_valid = 2'b11; sb_if.retire_rd = {5'd10, 5'd1};
        #1;
        check("flush_ready", 64'(sb_if.issue_ready), 64'd0);
        step();
        check("flush_busy", 64'(sb_if.reg_busy), 64'h0);
        check("flush_total", 64'(sb_if.outstanding_total), 64'd0);
        check("flush_no_uf", 64'(sb_if.underflow_error), 64'd0);

        // Dual retire to r7: counter 2 then counter 1 (clamped)
        issue_rd(5'd7); issue_rd(5'd7);
        check("r7_total2", 64'(sb_if.outstanding_total), 64'd2);
        sb_if.retire_valid = 2'b11; sb_if.retire_rd = {5'd7, 5'd7};
        step();
        check("r7_dual_total", 64'(sb_if.outstanding_total), 64'd0);
        check("r7_dual_busy", 64'(sb_if.reg_busy), 64'h0);
        check("r7_dual_uf", 64'(sb_if.underflow_error), 64'd0);
        issue_rd(5'd7);
        check("r7_total1", 64'(sb_if.outstanding_total), 64'd1);
        sb_if.retire_valid = 2'b11; sb_if.retire_rd = {5'd7, 5'd7};
        step();
        check("r7_clamp_total", 64'(sb_if.outstanding_total), 64'd0);
        check("r7_clamp_busy", 64'(sb_if.reg_busy), 64'h0);
        check("r7_clamp_uf", 64'(sb_if.underflow_error), 64'd1);
        sb_if.flush = 1'b1;
        step();
        check("uf_sticky_flush", 64'(sb_if.underflow_error), 64'd1);

        // Bypass on r9
        issue_rd(5'd9);
        sb_if.issue_rs2 = 5'd9; sb_if.issue_rs2_used = 1'b1;
        sb_if.bypass_valid = 1'b1; sb_if.bypass_reg = 5'd9;
        #1;
        check("byp_cnt1_ready", 64'(sb_if.issue_ready), 64'd1);
        sb_if.bypass_reg = 5'd8;
        #1;
        check("byp_wrong_reg", 64'(sb_if.issue_ready), 64'd0);
        idle();
        issue_rd(5'd9);
        sb_if.issue_rs2 = 5'd9; sb_if.issue_rs2_used = 1'b1;
        sb_if.bypass_valid = 1'b1; sb_if.bypass_reg = 5'd9;
        #1;
        check("byp_cnt2_blocked", 64'(sb_if.issue_ready), 64'd0);
        check("byp_total2", 64'(sb_if.outstanding_total), 64'd2);
        idle();

        // Asynchronous reset mid-stream (r9 still has 2 outstanding)
        issue_rd(5'd12);
        check("pre_rst_total", 64'(sb_if.outstanding_total), 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(sb_if.reg_busy), 64'h0);
        check("arst_total", 64'(sb_if.outstanding_total), 64'd0);
        check("arst_uf", 64'(sb_if.underflow_error), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", 64'(sb_if.issue_ready), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
